admm_iteration_controller: RTL and testbench

- Top-level ADMM loop sequencer. Drives the four per-iteration stages in order, each over a level start/done handshake: primal_update, slack_update, dual_update, then residual_calculator.
- Consumes the residual stage's converged/done outputs and decides whether to iterate again or terminate.
- Toggles the z/z_prev ping-pong bank select once per iteration.
- Counts iterations and reports solve status to the host-facing wrapper.

---
 rtl/admm_iteration_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_admm_iteration_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/admm_iteration_controller.sv
// ADMM loop sequencer: steps primal/slack/dual/residual stages over level start/done
// handshakes, counts iterations, flips the z ping-pong bank and reports solve status.
module admm_iteration_controller #(
    parameter int unsigned ITER_WIDTH     = 16,
    parameter int unsigned CHECK_INTERVAL = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TIMER_WIDTH    = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_solve,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] max_iter,
    output logic                  primal_start,
    input  logic                  primal_done,
    output logic                  slack_start,
    input  logic                  slack_done,
    output logic                  dual_start,
    input  logic                  dual_done,
    output logic                  resid_start,
    input  logic                  resid_done,
    input  logic                  resid_converged,
    output logic                  z_bank_sel,
    output logic                  busy,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  solve_done,
    output logic                  solve_converged,
    output logic                  timeout_err,
    output logic                  aborted
);

    localparam int unsigned INT_WIDTH = (CHECK_INTERVAL > 1) ? $clog2(CHECK_INTERVAL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIMAL,
        S_SLACK,
        S_DUAL,
        S_RESID,
        S_DECIDE,
        S_FINISH
    } state_t;

    typedef enum logic {
        PH_ASSERT,
        PH_RELEASE
    } phase_t;

    state_t                 state_q, state_d;
    phase_t                 phase_q, phase_d;
    logic [ITER_WIDTH-1:0]  max_iter_q, max_iter_d;
    logic [ITER_WIDTH-1:0]  iter_count_d;
    logic [INT_WIDTH-1:0]   int_cnt_q, int_cnt_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   conv_q, conv_d;
    logic                   z_bank_sel_d;
    logic                   busy_d;
    logic                   solve_done_d;
    logic                   solve_converged_d;
    logic                   timeout_err_d;
    logic                   aborted_d;
    logic                   primal_start_d, slack_start_d, dual_start_d, resid_start_d;

    logic                   stage_active;
    logic                   cur_done;
    logic                   phase_event;
    logic                   timer_expired;
    logic                   last_iter;
    logic                   interval_end;
    logic                   check_due;

    assign stage_active  = (state_q == S_PRIMAL) || (state_q == S_SLACK) ||
                           (state_q == S_DUAL)   || (state_q == S_RESID);
    assign cur_done      = (state_q == S_PRIMAL) ? primal_done :
                           (state_q == S_SLACK)  ? slack_done  :
                           (state_q == S_DUAL)   ? dual_done   :
                           (state_q == S_RESID)  ? resid_done  : 1'b0;
    // ASSERT waits for done high, RELEASE waits for it to fall back
    assign phase_event   = (phase_q == PH_ASSERT) ? cur_done : ~cur_done;
    assign timer_expired = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    assign last_iter     = ((iter_count + ITER_WIDTH'(1)) == max_iter_q);
    assign interval_end  = (int_cnt_q == INT_WIDTH'(CHECK_INTERVAL - 1));
    assign check_due     = interval_end || last_iter;

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            phase_q         <= PH_ASSERT;
            max_iter_q      <= '0;
            int_cnt_q       <= '0;
            timer_q         <= '0;
            conv_q          <= 1'b0;
            iter_count      <= '0;
            z_bank_sel      <= 1'b0;
            busy            <= 1'b0;
            solve_done      <= 1'b0;
            solve_converged <= 1'b0;
            timeout_err     <= 1'b0;
            aborted         <= 1'b0;
            primal_start    <= 1'b0;
            slack_start     <= 1'b0;
            dual_start      <= 1'b0;
            resid_start     <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            max_iter_q      <= max_iter_d;
            int_cnt_q       <= int_cnt_d;
            timer_q         <= timer_d;
            conv_q          <= conv_d;
            iter_count      <= iter_count_d;
            z_bank_sel      <= z_bank_sel_d;
            busy            <= busy_d;
            solve_done      <= solve_done_d;
            solve_converged <= solve_converged_d;
            timeout_err     <= timeout_err_d;
            aborted         <= aborted_d;
            primal_start    <= primal_start_d;
            slack_start     <= slack_start_d;
            dual_start      <= dual_start_d;
            resid_start     <= resid_start_d;
        end
    end

    // Next-state logic; abort outranks both handshake progress and the watchdog
    always_comb begin : next_state
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE: begin
                if (start_solve) begin
                    state_d = (max_iter == '0) ? S_FINISH : S_PRIMAL;
                    phase_d = PH_ASSERT;
                end
            end
            S_PRIMAL, S_SLACK, S_DUAL, S_RESID: begin
                if (abort) begin
                    state_d = S_FINISH;
                    phase_d = PH_ASSERT;
                end else if (phase_event) begin
                    if (phase_q == PH_ASSERT) begin
                        phase_d = PH_RELEASE;
                    end else begin
                        phase_d = PH_ASSERT;
                        case (state_q)
                            S_PRIMAL: state_d = S_SLACK;
                            S_SLACK:  state_d = S_DUAL;
                            S_DUAL:   state_d = check_due ? S_RESID : S_DECIDE;
                            default:  state_d = S_DECIDE;
                        endcase
                    end
                end else if (timer_expired) begin
                    state_d = S_FINISH;
                    phase_d = PH_ASSERT;
                end
            end
            S_DECIDE: begin
                phase_d = PH_ASSERT;
                if (abort || conv_q || last_iter) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_PRIMAL;
                end
            end
            S_FINISH: begin
                if (!start_solve) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = PH_ASSERT;
            end
        endcase
    end

    // Next values for counters, flags and the registered outputs
    always_comb begin : output_logic
        max_iter_d        = max_iter_q;
        iter_count_d      = iter_count;
        int_cnt_d         = int_cnt_q;
        conv_d            = conv_q;
        z_bank_sel_d      = z_bank_sel;
        solve_converged_d = solve_converged;
        timeout_err_d     = timeout_err;
        aborted_d         = aborted;
        timer_d           = '0;

        // Starts follow the next state, so at most one is ever high and all drop on exit
        primal_start_d = (state_d == S_PRIMAL) && (phase_d == PH_ASSERT);
        slack_start_d  = (state_d == S_SLACK)  && (phase_d == PH_ASSERT);
        dual_start_d   = (state_d == S_DUAL)   && (phase_d == PH_ASSERT);
        resid_start_d  = (state_d == S_RESID)  && (phase_d == PH_ASSERT);
        busy_d         = (state_d != S_IDLE) && (state_d != S_FINISH);
        solve_done_d   = (state_d == S_FINISH);

        if (stage_active && (state_d == state_q) && (phase_d == phase_q)) begin
            timer_d = timer_q + TIMER_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start_solve) begin
                    max_iter_d        = max_iter;
                    iter_count_d      = '0;
                    int_cnt_d         = '0;
                    conv_d            = 1'b0;
                    solve_converged_d = 1'b0;
                    timeout_err_d     = 1'b0;
                    aborted_d         = 1'b0;
                end
            end
            S_PRIMAL, S_SLACK, S_DUAL, S_RESID: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else if (!phase_event && timer_expired) begin
                    timeout_err_d = 1'b1;
                end else if ((state_q == S_RESID) && (phase_q == PH_ASSERT) && phase_event) begin
                    conv_d = resid_converged;
                end
            end
            S_DECIDE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    iter_count_d = iter_count + ITER_WIDTH'(1);
                    int_cnt_d    = interval_end ? '0 : int_cnt_q + INT_WIDTH'(1);
                    conv_d       = 1'b0;
                    if (conv_q) begin
                        solve_converged_d = 1'b1;
                    end else if (!last_iter) begin
                        z_bank_sel_d = ~z_bank_sel;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_admm_iteration_controller.sv
// Scoreboard bench for admm_iteration_controller: randomized stage responders, an
// iteration-level reference model, and a monitor checking stage order and solve results.
module tb_admm_iteration_controller;

    localparam int unsigned IW = 8;
    localparam int unsigned CI = 3;
    localparam int unsigned TO = 20;
    localparam int unsigned TW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_solve;
    logic          abort;
    logic [IW-1:0] max_iter;
    logic          primal_start, slack_start, dual_start, resid_start;
    logic          primal_done, slack_done, dual_done, resid_done, resid_converged;
    logic          z_bank_sel, busy, solve_done, solve_converged, timeout_err, aborted;
    logic [IW-1:0] iter_count;

    logic [3:0]    done_v;
    logic          resid_conv_v;
    logic [31:0]   cmask_cfg;
    int            hang_cfg;

    assign primal_done     = done_v[0];
    assign slack_done      = done_v[1];
    assign dual_done       = done_v[2];
    assign resid_done      = done_v[3];
    assign resid_converged = resid_conv_v;

    always #5 clk = ~clk;

    admm_iteration_controller #(
        .ITER_WIDTH     (IW),
        .CHECK_INTERVAL (CI),
        .TIMEOUT_CYCLES (TO),
        .TIMER_WIDTH    (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_solve     (start_solve),
        .abort           (abort),
        .max_iter        (max_iter),
        .primal_start    (primal_start),
        .primal_done     (primal_done),
        .slack_start     (slack_start),
        .slack_done      (slack_done),
        .dual_start      (dual_start),
        .dual_done       (dual_done),
        .resid_start     (resid_start),
        .resid_done      (resid_done),
        .resid_converged (resid_converged),
        .z_bank_sel      (z_bank_sel),
        .busy            (busy),
        .iter_count      (iter_count),
        .solve_done      (solve_done),
        .solve_converged (solve_converged),
        .timeout_err     (timeout_err),
        .aborted         (aborted)
    );

    typedef struct {
        int iters;
        bit conv;
        bit tmo;
        bit abt;
        bit z;
    } res_t;

    int   checks   = 0;
    int   failures = 0;
    int   exp_stage_q[$];
    res_t exp_res_q[$];
    bit   model_z = 1'b0;
    int   last_dual_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: whole-solve outcome from iteration-level rules
    task automatic model_solve(input int mi, input logic [31:0] cmask, input int hang_it,
                               input int abort_it);
        res_t r;
        bit   due;
        r.iters = 0; r.conv = 0; r.tmo = 0; r.abt = 0;
        for (int it = 1; it <= mi; it++) begin
            exp_stage_q.push_back(0);
            exp_stage_q.push_back(1);
            if (abort_it == it) begin r.abt = 1; r.iters = it - 1; break; end
            exp_stage_q.push_back(2);
            if (hang_it == it) begin r.tmo = 1; r.iters = it - 1; break; end
            due = ((it % CI) == 0) || (it == mi);
            if (due) exp_stage_q.push_back(3);
            if (due && cmask[it-1]) begin r.conv = 1; r.iters = it; break; end
            if (it == mi) begin r.iters = it; break; end
            model_z = ~model_z;
        end
        r.z = model_z;
        exp_res_q.push_back(r);
    endtask

    // Stage responders: done follows start after a random delay; dual can be made to hang
    initial begin
        int   dly[4];
        int   iter_no;
        logic prev_primal;
        logic [3:0] st;
        done_v = '0; resid_conv_v = 1'b0; iter_no = 0; prev_primal = 1'b0;
        for (int s = 0; s < 4; s++) dly[s] = 0;
        forever begin
            @(negedge clk);
            st = {resid_start, dual_start, slack_start, primal_start};
            if (!rst) begin
                done_v = '0;
                for (int s = 0; s < 4; s++) dly[s] = 0;
            end else begin
                if (!start_solve) iter_no = 0;
                else if (primal_start && !prev_primal) iter_no++;
                for (int s = 0; s < 4; s++) begin
                    if (st[s] != done_v[s]) begin
                        if (s == 2 && st[s] && iter_no == hang_cfg) begin
                        end else if (dly[s] == 0) begin
                            done_v[s] = st[s];
                            dly[s] = $urandom_range(0, 4);
                            if (s == 3 && st[s] && iter_no >= 1)
                                resid_conv_v = cmask_cfg[iter_no-1];
                        end else begin
                            dly[s]--;
                        end
                    end
                end
            end
            prev_primal = primal_start;
        end
    end

    // Monitor: stage start order, one-hot starts, dual start length, solve results
    initial begin
        logic [3:0] st, prev_st;
        logic       prev_done;
        int         dual_run;
        int         e;
        res_t       r;
        prev_st = '0; prev_done = 1'b0; dual_run = 0;
        forever begin
            @(negedge clk);
            st = {resid_start, dual_start, slack_start, primal_start};
            for (int s = 0; s < 4; s++) begin
                if (st[s] && !prev_st[s]) begin
                    check("start_onehot", $countones(st), 1);
                    if (exp_stage_q.size() == 0) begin
                        check("unexpected_start", s, 99);
                    end else begin
                        e = exp_stage_q.pop_front();
                        check("stage_order", s, e);
                    end
                end
            end
            if (dual_start) dual_run++;
            else if (dual_run > 0) begin last_dual_len = dual_run; dual_run = 0; end
            if (solve_done && !prev_done) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_solve_done", 1, 0);
                end else begin
                    r = exp_res_q.pop_front();
                    check("iter_count", iter_count, r.iters);
                    check("solve_converged", solve_converged, r.conv);
                    check("timeout_err", timeout_err, r.tmo);
                    check("aborted", aborted, r.abt);
                    check("z_bank_sel", z_bank_sel, r.z);
                    check("busy_at_done", busy, 0);
                end
            end
            prev_st = st;
            prev_done = solve_done;
        end
    end

    task automatic run_solve(input int mi, input logic [31:0] cmask, input int hang_it,
                             input int abort_it);
        int   n;
        int   cnt;
        logic prev;
        cmask_cfg = cmask;
        hang_cfg  = hang_it;
        model_solve(mi, cmask, hang_it, abort_it);
        max_iter    = IW'(mi);
        start_solve = 1'b1;
        if (abort_it > 0) begin
            cnt = 0; n = 0; prev = slack_start;
            while (cnt < abort_it && n < 3000) begin
                @(negedge clk);
                n++;
                if (slack_start && !prev) cnt++;
                prev = slack_start;
            end
            check("abort_reached_slack", cnt, abort_it);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            check("abort_drops_slack", slack_start, 0);
        end
        n = 0;
        while (!solve_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("solve_done_seen", solve_done, 1);
        if (mi == 0) check("max0_done_within_2", (n <= 2), 1);
        if (hang_it > 0) check("dual_start_len", last_dual_len, TO);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_solve = 1'b0;
        n = 0;
        while (solve_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("solve_done_release", solve_done, 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b0; start_solve = 1'b0; abort = 1'b0; max_iter = '0;
        cmask_cfg = '0; hang_cfg = 0;
        repeat (3) @(negedge clk);
        check("rst_starts", {primal_start, slack_start, dual_start, resid_start}, 0);
        check("rst_busy", busy, 0);
        check("rst_solve_done", solve_done, 0);
        check("rst_iter_count", iter_count, 0);
        check("rst_z_bank_sel", z_bank_sel, 0);
        check("rst_flags", {solve_converged, timeout_err, aborted}, 0);
        rst = 1'b1;
        @(negedge clk);

        run_solve(3, 32'h0, 0, 0);
        run_solve(10, 32'h4, 0, 0);
        run_solve(6, 32'h2, 0, 0);
        run_solve(0, 32'h0, 0, 0);
        run_solve(5, 32'h0, 2, 0);
        run_solve(5, 32'h0, 0, 2);
        run_solve(2, 32'h3, 0, 0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", {aborted, busy, primal_start}, 0);

        for (int k = 0; k < 25; k++) begin
            run_solve($urandom_range(0, 9), $urandom & $urandom & $urandom, 0, 0);
        end
        run_solve(20, 32'h0, 0, 0);

        cmask_cfg = '0; hang_cfg = 0;
        exp_stage_q.push_back(0);
        max_iter = IW'(5);
        start_solve = 1'b1;
        n = 0;
        while (!primal_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_primal", primal_start, 1);
        rst = 1'b0;
        #1;
        check("midrst_starts", {primal_start, slack_start, dual_start, resid_start}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_iter_z", {iter_count, z_bank_sel}, 0);
        model_z = 1'b0;
        start_solve = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("stage_queue_drained", exp_stage_q.size(), 0);
        check("result_queue_drained", exp_res_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
